// File: rtl/aurora_tx_frame_packer_if.sv
// Source-write and AXI-Stream transmit signals of the Aurora frame packer.
// master: the packer (accepts source words, drives the stream).
// slave: the environment (writes source words, consumes the stream).
interface aurora_tx_frame_packer_if;
  logic        src_en_i;
  logic [63:0] src_data_i;
  logic        src_full_o;
  logic        m_axis_tx_tvalid;
  logic [63:0] m_axis_tx_tdata;
  logic        m_axis_tx_tlast;
  logic        m_axis_tx_tready;

  modport master (
    input  src_en_i, src_data_i, m_axis_tx_tready,
    output src_full_o, m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast
  );

  modport slave (
    output src_en_i, src_data_i, m_axis_tx_tready,
    input  src_full_o, m_axis_tx_tvalid, m_axis_tx_tdata, m_axis_tx_tlast
  );
endinterface

// File: rtl/aurora_tx_frame_packer.sv
// Aurora TX framer: FWFT FIFO of 64-bit source words emitted as header/payload/tail frames.
// Latency: header valid one cycle after WAIT sees a full burst; frame is len+1 back-to-back beats.
// Backpressure: tready low holds tdata/tlast and stops FIFO pops; writes to a full FIFO are dropped.
module aurora_tx_frame_packer #(
  parameter int          FIFO_DEPTH = 512,
  parameter int          BURST_LEN  = 64,
  parameter logic [15:0] HDR_TAG    = 16'hA5A5,
  parameter logic [15:0] TAIL_TAG   = 16'h5A5A
) (
  input  logic                             aurora_log_clk,
  input  logic                             aurora_rst_n,
  input  logic                             tx_start_i,
  input  logic                             tx_end_i,
  input  logic [1:0]                       tx_mode_i,
  aurora_tx_frame_packer_if.master         bus,
  output logic                             tx_done_o,
  output logic                             overflow_o,
  output logic [15:0]                      frame_cnt_o
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]  BURST_C = CW'(BURST_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_HEAD, S_PAYLOAD, S_TAIL, S_DONE
  } state_t;

  // Header and tail share one layout; cnt is seq for headers, frame count for tails.
  typedef struct packed {
    logic [15:0] tag;
    logic [13:0] rsvd;
    logic [1:0]  mode;
    logic [15:0] cnt;
    logic [15:0] len;
  } hdr_t;

  logic [1:0]    rst_sync_q;
  logic          rst_n;

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full, push, pop, drop, start_edge;

  state_t        state_q;
  logic          start_d_q;
  logic [1:0]    mode_q;
  logic [15:0]   seq_q, frame_cnt_q;
  logic [CW-1:0] len_q, rem_q;
  hdr_t          hdr_q;
  logic          tvalid_q, tlast_q, done_q, overflow_q;

  // Reset asserts asynchronously and is released two clocks after the pin deasserts.
  always_ff @(posedge aurora_log_clk or negedge aurora_rst_n) begin
    if (!aurora_rst_n) rst_sync_q <= 2'b00;
    else               rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // A start edge wins over everything: writes in that cycle are discarded with the flush.
  assign start_edge = tx_start_i & ~start_d_q;
  assign full       = (count_q == DEPTH_C);
  assign pop        = (state_q == S_PAYLOAD) & tvalid_q & bus.m_axis_tx_tready;
  assign push       = bus.src_en_i & ~full & (state_q != S_IDLE) & ~start_edge;
  assign drop       = bus.src_en_i &  full & (state_q != S_IDLE) & ~start_edge;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage: no reset needed, occupancy tracks which entries are live.
  always_ff @(posedge aurora_log_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.src_data_i;
  end

  // FIFO pointers and occupancy, flushed by a session start.
  always_ff @(posedge aurora_log_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (start_edge) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Framing FSM with registered stream/status outputs.
  always_ff @(posedge aurora_log_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      start_d_q   <= 1'b0;
      mode_q      <= 2'd0;
      seq_q       <= 16'd0;
      frame_cnt_q <= 16'd0;
      len_q       <= '0;
      rem_q       <= '0;
      hdr_q       <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      start_d_q <= tx_start_i;
      done_q    <= 1'b0;
      if (drop) overflow_q <= 1'b1;
      if (start_edge) begin
        // Restart abandons any frame in flight; the receiver discards the partial frame.
        state_q     <= S_WAIT;
        mode_q      <= tx_mode_i;
        seq_q       <= 16'd0;
        frame_cnt_q <= 16'd0;
        overflow_q  <= 1'b0;
        tvalid_q    <= 1'b0;
        tlast_q     <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_WAIT: begin
            if (count_q >= BURST_C) begin
              len_q    <= BURST_C;
              hdr_q    <= '{tag: HDR_TAG, rsvd: 14'd0, mode: mode_q, cnt: seq_q, len: 16'(BURST_C)};
              tvalid_q <= 1'b1;
              tlast_q  <= 1'b0;
              state_q  <= S_HEAD;
            end else if (tx_end_i && (count_q != '0)) begin
              // Closing short frame: everything currently buffered.
              len_q    <= count_q;
              hdr_q    <= '{tag: HDR_TAG, rsvd: 14'd0, mode: mode_q, cnt: seq_q, len: 16'(count_q)};
              tvalid_q <= 1'b1;
              tlast_q  <= 1'b0;
              state_q  <= S_HEAD;
            end else if (tx_end_i) begin
              hdr_q    <= '{tag: TAIL_TAG, rsvd: 14'd0, mode: mode_q, cnt: frame_cnt_q, len: 16'd0};
              tvalid_q <= 1'b1;
              tlast_q  <= 1'b1;
              state_q  <= S_TAIL;
            end
          end
          S_HEAD: begin
            if (bus.m_axis_tx_tready) begin
              rem_q   <= len_q;
              tlast_q <= (len_q == CW'(1));
              state_q <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            if (bus.m_axis_tx_tready) begin
              if (tlast_q) begin
                seq_q       <= seq_q + 16'd1;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                tvalid_q    <= 1'b0;
                tlast_q     <= 1'b0;
                state_q     <= S_WAIT;
              end else begin
                rem_q   <= rem_q - CW'(1);
                tlast_q <= (rem_q == CW'(2));
              end
            end
          end
          S_TAIL: begin
            if (bus.m_axis_tx_tready) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Payload beats come straight from the FIFO head; header and tail from the staged word.
  assign bus.m_axis_tx_tdata  = (state_q == S_PAYLOAD) ? mem_q[rd_ptr_q] : hdr_q;
  assign bus.m_axis_tx_tvalid = tvalid_q;
  assign bus.m_axis_tx_tlast  = tlast_q;
  assign bus.src_full_o       = full;
  assign tx_done_o            = done_q;
  assign overflow_o           = overflow_q;
  assign frame_cnt_o          = frame_cnt_q;

endmodule

// File: tb/tb_aurora_tx_frame_packer.sv
// Bench for aurora_tx_frame_packer: session-level stream model plus per-cycle output checks.
// Latency: n/a.
// Backpressure: tready is driven always-high, random, or held low depending on the test.
module tb_aurora_tx_frame_packer;
  localparam int BL = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start_i = 1'b0;
  logic        tx_end_i = 1'b0;
  logic [1:0]  tx_mode_i = 2'd0;
  logic        tx_done_o, overflow_o;
  logic [15:0] frame_cnt_o;

  aurora_tx_frame_packer_if bus_if ();

  aurora_tx_frame_packer #(.FIFO_DEPTH(512), .BURST_LEN(BL), .HDR_TAG(16'hA5A5), .TAIL_TAG(16'h5A5A)) dut (
    .aurora_log_clk (clk),
    .aurora_rst_n   (rst_n),
    .tx_start_i     (tx_start_i),
    .tx_end_i       (tx_end_i),
    .tx_mode_i      (tx_mode_i),
    .bus            (bus_if),
    .tx_done_o      (tx_done_o),
    .overflow_o     (overflow_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] dat; logic last; logic tail; } beat_t;

  int          n_cmp = 0, n_err = 0;
  int          rdy_mode = 0;
  logic [63:0] sess_words [0:1023];
  int          sess_n = 0;
  logic [1:0]  sess_mode = 2'd0;

  beat_t       exp_q [$];
  beat_t       e;
  logic [63:0] sess_beats [$];
  logic        mon_en = 1'b0;
  logic        prev_start = 1'b0, stall_prev = 1'b0, restart_prev = 1'b0, done_exp = 1'b0;
  logic [63:0] stall_dat;
  logic        stall_last;
  logic [15:0] mcnt = 16'd0;
  int          acc_cnt = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected stream of a whole session: full bursts, one short remainder frame, then the tail.
  task automatic build_session();
    int idx = 0;
    int nf = (sess_n + BL - 1) / BL;
    beat_t b;
    exp_q.delete();
    for (int f = 0; f < nf; f++) begin
      int len = (sess_n - idx > BL) ? BL : sess_n - idx;
      b.dat = {16'hA5A5, 14'd0, sess_mode, 16'(f), 16'(len)}; b.last = 1'b0; b.tail = 1'b0;
      exp_q.push_back(b);
      for (int j = 0; j < len; j++) begin
        b.dat = sess_words[idx]; b.last = (j == len - 1); b.tail = 1'b0;
        exp_q.push_back(b);
        idx++;
      end
    end
    b.dat = {16'h5A5A, 14'd0, sess_mode, 16'(nf), 16'd0}; b.last = 1'b1; b.tail = 1'b1;
    exp_q.push_back(b);
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        chk("stall_tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'd1);
        chk("stall_tdata", bus_if.m_axis_tx_tdata, stall_dat);
        chk("stall_tlast", 64'(bus_if.m_axis_tx_tlast), 64'(stall_last));
      end
      if (restart_prev) chk("restart_tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'd0);
      chk("tx_done", 64'(tx_done_o), 64'(done_exp));
      chk("frame_cnt", 64'(frame_cnt_o), 64'(mcnt));
      done_exp = 1'b0;
      if (bus_if.m_axis_tx_tvalid && bus_if.m_axis_tx_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", bus_if.m_axis_tx_tdata, 64'hxxxx_xxxx_xxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", bus_if.m_axis_tx_tdata, e.dat);
          chk("tlast", 64'(bus_if.m_axis_tx_tlast), 64'(e.last));
          if (e.tail) done_exp = 1'b1;
          else if (e.last) mcnt = mcnt + 16'd1;
        end
        sess_beats.push_back(bus_if.m_axis_tx_tdata);
        acc_cnt++;
      end
      if (tx_done_o) done_cnt++;
      stall_prev   = bus_if.m_axis_tx_tvalid & ~bus_if.m_axis_tx_tready;
      stall_dat    = bus_if.m_axis_tx_tdata;
      stall_last   = bus_if.m_axis_tx_tlast;
      restart_prev = 1'b0;
      if (tx_start_i && !prev_start) begin
        build_session();
        sess_beats.delete();
        mcnt = 16'd0; acc_cnt = 0; done_exp = 1'b0;
        stall_prev = 1'b0; restart_prev = 1'b1;
      end
    end else begin
      stall_prev = 1'b0; restart_prev = 1'b0; done_exp = 1'b0;
    end
    prev_start = tx_start_i;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus_if.m_axis_tx_tready = 1'b1;
      1:       bus_if.m_axis_tx_tready = ($urandom % 3) != 0;
      default: bus_if.m_axis_tx_tready = 1'b0;
    endcase
  endtask

  task automatic start_session(input logic [1:0] mode, input int n_exp, input int n_wr, input bit seq_data);
    for (int i = 0; i < n_wr; i++) sess_words[i] = seq_data ? 64'(i) : {$urandom, $urandom};
    sess_n = n_exp; sess_mode = mode;
    tx_mode_i = mode; tx_start_i = 1'b1;
    tick();
    tx_start_i = 1'b0;
  endtask

  task automatic write_words(input int n, input bit gated);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      if (gated) begin
        bus_if.src_en_i = 1'b0;
        while (($urandom % 4) == 0) tick();
        while (bus_if.src_full_o && k < 5000) begin tick(); k++; end
        if (k >= 5000) chk("full_wait_timeout", 64'd1, 64'd0);
      end
      bus_if.src_en_i = 1'b1; bus_if.src_data_i = sess_words[i];
      tick();
    end
    bus_if.src_en_i = 1'b0;
  endtask

  task automatic end_and_wait();
    int d0 = done_cnt;
    int k = 0;
    tx_end_i = 1'b1;
    while (done_cnt == d0 && k < 20000) begin tick(); k++; end
    if (k >= 20000) chk("done_timeout", 64'd1, 64'd0);
    tx_end_i = 1'b0;
    tick(); tick();
    chk("stream_drained", 64'(exp_q.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_cnt < n && k < 5000) begin tick(); k++; end
    if (k >= 5000) chk("beat_wait_timeout", 64'(acc_cnt), 64'(n));
  endtask

  initial begin
    bus_if.src_en_i = 1'b0; bus_if.src_data_i = '0; bus_if.m_axis_tx_tready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Reset state
    chk("rst_tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'd0);
    chk("rst_tlast", 64'(bus_if.m_axis_tx_tlast), 64'd0);
    chk("rst_tdata", bus_if.m_axis_tx_tdata, 64'd0);
    chk("rst_done", 64'(tx_done_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt_o), 64'd0);
    chk("rst_full", 64'(bus_if.src_full_o), 64'd0);
    mon_en = 1'b1;

    // Two full frames, words 0..127
    rdy_mode = 0;
    start_session(2'd0, 128, 128, 1'b1);
    write_words(128, 1'b0);
    end_and_wait();
    chk("t1_size", 64'(sess_beats.size()), 64'd131);
    chk("t1_hdr0", sess_beats[0], 64'hA5A5_0000_0000_0040);
    chk("t1_word0", sess_beats[1], 64'd0);
    chk("t1_hdr1", sess_beats[65], 64'hA5A5_0000_0001_0040);
    chk("t1_word64", sess_beats[66], 64'd64);
    chk("t1_tail", sess_beats[130], 64'h5A5A_0000_0002_0000);

    // Short final frame
    start_session(2'd1, 70, 70, 1'b0);
    write_words(70, 1'b0);
    end_and_wait();
    chk("t2_size", 64'(sess_beats.size()), 64'd73);
    chk("t2_hdr1", sess_beats[65], 64'hA5A5_0001_0001_0006);
    chk("t2_tail", sess_beats[72], 64'h5A5A_0001_0002_0000);

    // Random backpressure and random session lengths
    rdy_mode = 1;
    for (int s = 0; s < 3; s++) begin
      int n = $urandom_range(1, 300);
      start_session(2'($urandom_range(0, 2)), n, n, 1'b0);
      write_words(n, 1'b1);
      end_and_wait();
      chk("t3_size", 64'(sess_beats.size()), 64'(n + (n + BL - 1) / BL + 1));
    end

    // Overflow: 520 writes into 512 entries with the link stalled
    rdy_mode = 2;
    start_session(2'd2, 512, 520, 1'b0);
    for (int i = 0; i < 520; i++) begin
      bus_if.src_en_i = 1'b1; bus_if.src_data_i = sess_words[i];
      tick();
      if (i == 510) chk("t4_not_full_511", 64'(bus_if.src_full_o), 64'd0);
      if (i == 511) begin
        chk("t4_full_512", 64'(bus_if.src_full_o), 64'd1);
        chk("t4_no_ovf_yet", 64'(overflow_o), 64'd0);
      end
    end
    bus_if.src_en_i = 1'b0;
    chk("t4_overflow", 64'(overflow_o), 64'd1);
    rdy_mode = 1;
    end_and_wait();
    chk("t4_size", 64'(sess_beats.size()), 64'd521);
    chk("t4_tail", sess_beats[520], 64'h5A5A_0002_0008_0000);
    chk("t4_overflow_sticky", 64'(overflow_o), 64'd1);

    // Restart during word 30 of the second frame
    rdy_mode = 0;
    start_session(2'd0, 128, 128, 1'b0);
    chk("t5_overflow_cleared", 64'(overflow_o), 64'd0);
    write_words(128, 1'b0);
    wait_acc(95);
    chk("t5_frame_cnt_before", 64'(frame_cnt_o), 64'd1);
    start_session(2'd1, 20, 20, 1'b0);
    chk("t5_frame_cnt_after", 64'(frame_cnt_o), 64'd0);
    write_words(20, 1'b0);
    end_and_wait();
    chk("t5_size", 64'(sess_beats.size()), 64'd22);
    chk("t5_hdr", sess_beats[0], 64'hA5A5_0001_0000_0014);
    chk("t5_tail", sess_beats[21], 64'h5A5A_0001_0001_0000);

    // Empty session
    start_session(2'd2, 0, 0, 1'b0);
    repeat (3) tick();
    end_and_wait();
    chk("t6_size", 64'(sess_beats.size()), 64'd1);
    chk("t6_tail", sess_beats[0], 64'h5A5A_0002_0000_0000);
    repeat (3) tick();
    chk("t6_idle_tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'd0);

    // Asynchronous reset while a header is stalled
    rdy_mode = 2;
    start_session(2'd0, 64, 64, 1'b0);
    write_words(64, 1'b0);
    repeat (3) tick();
    chk("t7_pre_reset_tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'd1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'd0);
    chk("t7_async_full", 64'(bus_if.src_full_o), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t7_post_tvalid", 64'(bus_if.m_axis_tx_tvalid), 64'd0);
    chk("t7_post_frame_cnt", 64'(frame_cnt_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aurora_tx_frame_packer.md
# aurora_tx_frame_packer

Transmit-side framer for the Aurora link that feeds the PCIe receive merge path. It buffers 64-bit source words (PMT/encoder packed words, EDS or FBC data) in an internal FWFT FIFO and emits them as framed AXI-Stream bursts: header, fixed-length payload, and a closing tail frame. A session starts on the rising edge of `tx_start_i` and ends on `tx_end_i`, mirroring the start/end handshake of the receive side.

## Interface
- `FIFO_DEPTH`, 512: source FIFO depth in 64-bit words, power of two.
- `BURST_LEN`, 64: payload words per full frame, 1..FIFO_DEPTH.
- `HDR_TAG`, 16'hA5A5: header marker.
- `TAIL_TAG`, 16'h5A5A: tail marker.

Ports:
- `aurora_log_clk` input 1: single clock for all logic.
- `aurora_rst_n` input 1: asynchronous, active-low reset.
- `tx_start_i` input 1: session level; its rising edge starts or restarts a session.
- `tx_end_i` input 1: level; request to flush and close the session.
- `tx_mode_i` input 2: 0=PMT, 1=EDS, 2=FBC; sampled at the start edge.
- `src_en_i` input 1: source write strobe.
- `src_data_i` input 64: source word.
- `src_full_o` output 1: FIFO full.
- `m_axis_tx_tvalid` output 1: output word valid.
- `m_axis_tx_tdata` output 64: output word.
- `m_axis_tx_tlast` output 1: last word of a frame.
- `m_axis_tx_tready` input 1: link ready.
- `tx_done_o` output 1: one-cycle pulse when the tail word is accepted.
- `overflow_o` output 1: sticky; a write was dropped while the FIFO was full.
- `frame_cnt_o` output 16: data frames sent in the current session.

## Operation
- **States:** IDLE, WAIT, HEAD, PAYLOAD, TAIL, DONE.
- **Start edge:** detect `tx_start_i & ~tx_start_d`. In any state, this forces WAIT on the next cycle. It also flushes the FIFO, clears `frame_cnt_o`, `seq` and `overflow_o`, latches `tx_mode_i`, and drops `tvalid` immediately. The receiver discards a partial frame on restart.
- **IDLE:** no output activity. Source writes are dropped and `overflow_o` is not set.
- **WAIT:**
  - If FIFO count ≥ BURST_LEN: go to HEAD with `len = BURST_LEN`.
  - Else if `tx_end_i` and count > 0: go to HEAD with `len = count`.
  - Else if `tx_end_i` and count = 0: go to TAIL.
- **HEAD:** drive `{HDR_TAG, 14'd0, mode[1:0], seq[15:0], len[15:0]}` with `tlast = 0`. On accept, go to PAYLOAD.
- **PAYLOAD:**
  - Drive the FIFO head word and pop it on each accept (`tvalid & tready`).
  - `tlast = 1` on word number `len`. On that accept: `seq++`, `frame_cnt_o++`, return to WAIT.
  - The payload never underflows, because `len` ≤ count when the frame begins.
- **TAIL:** drive `{TAIL_TAG, 14'd0, mode, frame_cnt_o[15:0], 16'd0}` with `tlast = 1`. On accept, go to DONE.
- **DONE:** pulse `tx_done_o` for one cycle, then go to IDLE.
- **FIFO:** synchronous FWFT with an occupancy counter of width log2(FIFO_DEPTH)+1.
  - A simultaneous push and pop leaves the count unchanged.
  - Pushes are accepted whenever not full, including during HEAD and PAYLOAD.
  - A write while full is dropped and sets `overflow_o`.
- **Counter wrap:** `seq` and `frame_cnt_o` wrap 16'hFFFF → 0.
- **Late end:** `tx_end_i` asserted during HEAD or PAYLOAD does not shorten the current frame. It is acted on at the next WAIT.

## Timing
- **Reset values:** all outputs 0, state IDLE, FIFO empty, counters 0.
- **Start latency:** start edge at cycle N, state is WAIT at N+1.
- **Header latency:** if FIFO count ≥ BURST_LEN is seen in WAIT at cycle M, header `tvalid` is asserted at M+1.
- **Stall rule:** while `tvalid & ~tready`, `tdata` and `tlast` hold stable and no pop occurs.
- **Throughput:** with `tready` held high, a full frame is BURST_LEN+1 consecutive beats. WAIT adds one idle cycle between frames.
- **Done pulse:** `tx_done_o` is asserted the cycle after the tail word is accepted.
- **Full flag:** `src_full_o` is combinational from the occupancy counter.
- **Async reset:** reset mid-frame drops `tvalid` asynchronously. Deassertion is synchronised internally before the logic leaves reset.

## Test plan
- **Full frame:** BURST_LEN=64, `tready`=1, start with mode=0, write 128 words 0..127, then raise `tx_end_i` → two frames: header seq 0 len 64 + words 0..63, header seq 1 len 64 + words 64..127, then tail `{5A5A, …, 0002, 0000}`; `tx_done_o` pulses once.
- **Short final frame:** write 70 words, then end → frame of len 64, frame of len 6 with `tlast` on the 6th word, tail count 2.
- **Backpressure:** toggle `tready` pseudo-randomly → payload order 0..N-1 is preserved, `tdata` holds through every stall, and no word is lost or duplicated.
- **Overflow:** FIFO_DEPTH=512, `tready`=0, write 520 words → `src_full_o`=1 after 512 words, `overflow_o`=1, and exactly 512 words are later delivered.
- **Restart mid-payload:** start edge during word 30 of a frame → `tvalid`=0 next cycle, FIFO empty, `frame_cnt_o`=0; the next header carries seq 0.
- **Empty end:** start, then end with no writes → only the tail word with count 0 is sent; `tx_done_o` pulses; state returns to IDLE.
